// File: rtl/player_vertical_motion.sv
// ---------------------------------------------------------------------------
// player_vertical_motion
// Per-player vertical physics integrator. It applies gravity, jumps (with a
// limited number of jumps per landing), snaps to the platform on landing and
// respawns the player after falling off the bottom of the screen. It drives
// y_pos / next_y into the platform collision checker and samples the checker's
// touching_platform result once per video frame.
//
// Ports:
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   frame_tick        in   1-cycle pulse per frame; all physics state updates on it
//   jump_btn          in   synchronised jump button level
//   touching_platform in   checker result for the current (y_pos, next_y)
//   y_pos             out  11-bit signed top-of-sprite y (registered)
//   next_y            out  y_pos + y_vel, combinational from registers
//   y_vel             out  11-bit signed vertical velocity, + is down (registered)
//   grounded          out  1 while standing on the platform
//   jumps_left        out  remaining jumps before the next landing
//   visible           out  0 while waiting to respawn
// ---------------------------------------------------------------------------
module player_vertical_motion #(
  parameter int HEIGHT     = 16,
  parameter int PLATFORM_Y = 380,
  parameter int SPAWN_Y    = 100,
  parameter int GRAVITY    = 1,
  parameter int JUMP_VEL   = 12,
  parameter int MAX_FALL   = 10,
  parameter int MAX_JUMPS  = 2,
  parameter int KILL_Y     = 520,
  parameter int RESPAWN_FR = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               jump_btn,
  input  logic               touching_platform,
  output logic signed [10:0] y_pos,
  output logic signed [10:0] next_y,
  output logic signed [10:0] y_vel,
  output logic               grounded,
  output logic [1:0]         jumps_left,
  output logic               visible
);

  localparam logic [1:0] GROUNDED = 2'd0;
  localparam logic [1:0] RISING   = 2'd1;
  localparam logic [1:0] FALLING  = 2'd2;
  localparam logic [1:0] RESPAWN  = 2'd3;

  localparam int CNT_W = (RESPAWN_FR > 1) ? $clog2(RESPAWN_FR) : 1;

  localparam logic signed [10:0] SPAWN_V  = 11'(SPAWN_Y);
  localparam logic signed [10:0] LAND_V   = 11'(PLATFORM_Y - 2 * HEIGHT);
  localparam logic signed [10:0] JUMP_V   = 11'(-JUMP_VEL);
  localparam logic signed [10:0] GRAV_V   = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF_V   = 11'(MAX_FALL);
  localparam logic signed [10:0] KILL_V   = 11'(KILL_Y);
  localparam logic signed [10:0] ZERO_V   = 11'sd0;
  localparam logic [1:0]         MAX_J    = 2'(MAX_JUMPS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RESPAWN_FR - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);

  logic [1:0]         state_r,   state_s;
  logic signed [10:0] y_pos_r,   y_pos_s;
  logic signed [10:0] y_vel_r,   y_vel_s;
  logic [1:0]         jumps_r,   jumps_s;
  logic [CNT_W-1:0]   resp_cnt_r, resp_cnt_s;
  logic               jump_btn_d_r;
  logic               jump_pend_r;

  logic               jump_edge_s;
  logic               jump_req_s;
  logic signed [10:0] next_y_s;
  logic signed [10:0] vel_sum_s;
  logic signed [10:0] vel_sat_s;
  logic [1:0]         jumps_dec_s;
  logic               can_jump_s;

  // Press detection; a press arriving on the tick cycle is used by that tick.
  assign jump_edge_s = jump_btn & ~jump_btn_d_r;
  assign jump_req_s  = jump_pend_r | jump_edge_s;

  assign next_y_s    = y_pos_r + y_vel_r;
  assign vel_sum_s   = y_vel_r + GRAV_V;
  assign vel_sat_s   = (vel_sum_s > MAXF_V) ? MAXF_V : vel_sum_s;
  assign jumps_dec_s = (jumps_r != 2'd0) ? (jumps_r - 2'd1) : 2'd0;
  assign can_jump_s  = jump_req_s && (jumps_r != 2'd0);

  // Per-frame physics update; everything holds between ticks.
  always_comb begin
    state_s    = state_r;
    y_pos_s    = y_pos_r;
    y_vel_s    = y_vel_r;
    jumps_s    = jumps_r;
    resp_cnt_s = resp_cnt_r;
    if (frame_tick) begin
      case (state_r)
        GROUNDED: begin
          if (can_jump_s) begin
            y_vel_s = JUMP_V;
            y_pos_s = y_pos_r + JUMP_V;
            jumps_s = jumps_dec_s;
            state_s = RISING;
          end else if (!touching_platform) begin
            // walked off the edge: the ground jump is forfeited
            y_vel_s = GRAV_V;
            jumps_s = jumps_dec_s;
            state_s = FALLING;
          end else begin
            y_vel_s = ZERO_V;
          end
        end
        RISING, FALLING: begin
          if (y_pos_r > KILL_V) begin
            y_vel_s    = ZERO_V;
            resp_cnt_s = CNT_ZERO;
            state_s    = RESPAWN;
          end else if (can_jump_s) begin
            y_pos_s = next_y_s;
            y_vel_s = JUMP_V;
            jumps_s = jumps_dec_s;
            state_s = RISING;
          end else if (touching_platform && !y_vel_r[10]) begin
            // contact only counts while moving down; rising passes through
            y_pos_s = LAND_V;
            y_vel_s = ZERO_V;
            jumps_s = MAX_J;
            state_s = GROUNDED;
          end else begin
            y_pos_s = next_y_s;
            y_vel_s = vel_sat_s;
            state_s = vel_sat_s[10] ? RISING : FALLING;
          end
        end
        RESPAWN: begin
          if (resp_cnt_r == CNT_LAST) begin
            y_pos_s = SPAWN_V;
            y_vel_s = ZERO_V;
            jumps_s = 2'd0;
            state_s = FALLING;
          end else begin
            resp_cnt_s = resp_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = FALLING;
        end
      endcase
    end else begin
      state_s    = state_r;
      resp_cnt_s = resp_cnt_r;
    end
  end

  // State registers and jump latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FALLING;
      y_pos_r      <= SPAWN_V;
      y_vel_r      <= ZERO_V;
      jumps_r      <= 2'd0;
      resp_cnt_r   <= CNT_ZERO;
      jump_btn_d_r <= 1'b0;
      jump_pend_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      y_pos_r      <= y_pos_s;
      y_vel_r      <= y_vel_s;
      jumps_r      <= jumps_s;
      resp_cnt_r   <= resp_cnt_s;
      jump_btn_d_r <= jump_btn;
      jump_pend_r  <= frame_tick ? 1'b0 : (jump_pend_r | jump_edge_s);
    end
  end

  assign y_pos      = y_pos_r;
  assign y_vel      = y_vel_r;
  assign next_y     = next_y_s;
  assign jumps_left = jumps_r;
  assign grounded   = (state_r == GROUNDED);
  assign visible    = (state_r != RESPAWN);

endmodule

// File: tb/tb_player_vertical_motion.sv
// Scoreboard bench for player_vertical_motion: the driver advances a
// behavioural player model on each frame tick and queues the expected
// outputs; a monitor compares the DUT the cycle after every tick.
module tb_player_vertical_motion;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               jump_btn = 1'b0;
  logic               touching_platform = 1'b0;
  logic signed [10:0] y_pos, next_y, y_vel;
  logic               grounded, visible;
  logic [1:0]         jumps_left;

  player_vertical_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .jump_btn(jump_btn),
    .touching_platform(touching_platform), .y_pos(y_pos), .next_y(next_y),
    .y_vel(y_vel), .grounded(grounded), .jumps_left(jumps_left), .visible(visible)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int v; int ny; int j; int g; int vis; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: ground, airborne (rising and falling are one mode) or dead.
  localparam int M_GND = 0, M_AIR = 1, M_DEAD = 2;
  int m_mode, m_y, m_v, m_j, m_cnt;
  bit m_pend;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
  endtask

  task automatic model_reset();
    m_mode = M_AIR; m_y = 100; m_v = 0; m_j = 0; m_cnt = 0; m_pend = 1'b0;
  endtask

  task automatic model_tick(input bit req, input bit touch);
    case (m_mode)
      M_GND: begin
        if (req && m_j > 0) begin
          m_v = -12; m_y = m_y - 12; m_j--; m_mode = M_AIR;
        end else if (!touch) begin
          m_v = 1; if (m_j > 0) m_j--; m_mode = M_AIR;
        end
      end
      M_AIR: begin
        if (m_y > 520) begin
          m_mode = M_DEAD; m_cnt = 0; m_v = 0;
        end else if (req && m_j > 0) begin
          m_y = m_y + m_v; m_v = -12; m_j--;
        end else if (touch && m_v >= 0) begin
          m_y = 348; m_v = 0; m_j = 2; m_mode = M_GND;
        end else begin
          m_y = m_y + m_v; m_v = (m_v + 1 > 10) ? 10 : m_v + 1;
        end
      end
      default: begin
        if (m_cnt == 59) begin
          m_y = 100; m_v = 0; m_j = 0; m_mode = M_AIR;
        end else m_cnt++;
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.y = m_y; e.v = m_v; e.ny = m_y + m_v; e.j = m_j;
    e.g = (m_mode == M_GND) ? 1 : 0;
    e.vis = (m_mode == M_DEAD) ? 0 : 1;
    return e;
  endfunction

  // Driver primitives: inputs change 1 time unit after a rising edge.
  task automatic press();
    jump_btn = 1'b1;
    m_pend = 1'b1;
    @(posedge clk); #1;
    jump_btn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tick(input bit touch, input bit press_now);
    touching_platform = touch;
    frame_tick = 1'b1;
    if (press_now) jump_btn = 1'b1;
    model_tick(m_pend | press_now, touch);
    m_pend = 1'b0;
    exp_q.push_back(model_out());
    @(posedge clk); #1;
    frame_tick = 1'b0;
    jump_btn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_y_pos"}, int'(y_pos), 100);
    chk({tag, "_y_vel"}, int'(y_vel), 0);
    chk({tag, "_next_y"}, int'(next_y), 100);
    chk({tag, "_jumps"}, int'(jumps_left), 0);
    chk({tag, "_grounded"}, int'(grounded), 0);
    chk({tag, "_visible"}, int'(visible), 1);
  endtask

  // Monitor: the cycle after each tick, pop the expectation and compare.
  logic mon_flag = 1'b0;
  always @(posedge clk) mon_flag <= frame_tick;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_flag) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("y_pos", int'(y_pos), e.y);
          chk("y_vel", int'(y_vel), e.v);
          chk("next_y", int'(next_y), e.ny);
          chk("jumps_left", int'(jumps_left), e.j);
          chk("grounded", int'(grounded), e.g);
          chk("visible", int'(visible), e.vis);
        end
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fall from spawn, land on the tick where y_vel is 7.
    repeat (7) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    // Ground jump, air jump, third press ignored.
    press(); tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    press(); tick(1'b0, 1'b0);
    press(); tick(1'b0, 1'b0);
    // Touching while rising passes through the platform.
    tick(1'b1, 1'b0);
    guard = 0;
    while (m_v < 0 && guard < 40) begin tick(1'b0, 1'b0); guard++; end
    tick(1'b1, 1'b0);

    // Press on the same cycle as the tick, then land by touching throughout.
    tick(1'b1, 1'b1);
    guard = 0;
    while (m_mode != M_GND && guard < 40) begin tick(1'b1, 1'b0); guard++; end
    chk("land_after_tick_press", int'(m_mode == M_GND), 1);

    // Walk off the edge, fall to saturation and past the kill line.
    tick(1'b0, 1'b0);
    guard = 0;
    while (m_mode != M_DEAD && guard < 200) begin tick(1'b0, 1'b0); guard++; end
    chk("reached_respawn", int'(m_mode == M_DEAD), 1);
    guard = 0;
    while (m_mode == M_DEAD && guard < 100) begin
      if ($urandom_range(0, 3) == 0) press();
      tick(1'b0, 1'b0);
      guard++;
    end
    chk("respawn_frames", guard, 60);

    // Randomised play.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 15) press();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      tick($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5);
    end

    // Fall off again and reset in the middle of the respawn wait.
    guard = 0;
    while (m_mode != M_DEAD && guard < 300) begin tick(1'b0, 1'b0); guard++; end
    repeat (10) tick(1'b0, 1'b0);
    chk("pre_reset_invisible", int'(visible), 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("mid_respawn_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) tick(1'b0, 1'b0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin @(posedge clk); guard++; end
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
